// File: rtl/sys_ctrl_param.sv
// ---------------------------------------------------------------------------
// sys_ctrl_param
//   UART command controller. It parses command frames that arrive byte by byte
//   from the RX synchroniser, drives the register-file and ALU strobes, and
//   pushes response bytes into the TX FIFO. The FIFO back-pressure is
//   honoured. An inactivity timeout aborts stalled frames.
//
//   Frames (first byte is the opcode):
//     OP_WR    addr, data        -> register write
//     OP_RD    addr              -> register read, 1 response byte
//     OP_ALU   a, b, fun         -> write a/b to reg 0/1, run ALU, RES_BYTES response bytes
//     OP_ALUNP fun               -> run ALU on current operands, RES_BYTES response bytes
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_rx_p_data/_d_vld   RX byte and its one-cycle valid pulse
//   i_rd_data/_valid     register-file read return
//   i_alu_out/i_out_valid ALU result (RES_BYTES*DATA_WIDTH) and valid
//   i_fifo_full          TX FIFO full
//   o_alu_en, o_alu_fun, o_clkg_en   ALU control
//   o_clkdiv_en          clock-divider enable (1 once out of reset)
//   o_address, o_wr_en, o_rd_en, o_wr_data   register-file access
//   o_wr_data_fifo, o_wr_inc         TX FIFO write
//   o_frame_err          one-cycle error pulse
//   All outputs are registered.
// ---------------------------------------------------------------------------
module sys_ctrl_param #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RES_BYTES  = 2,
  parameter int                    TIMEOUT    = 1023,
  parameter logic [DATA_WIDTH-1:0] OP_WR      = 'hAA,
  parameter logic [DATA_WIDTH-1:0] OP_RD      = 'hBB,
  parameter logic [DATA_WIDTH-1:0] OP_ALU     = 'hCC,
  parameter logic [DATA_WIDTH-1:0] OP_ALUNP   = 'hDD
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [DATA_WIDTH-1:0]           i_rx_p_data,
  input  logic                            i_rx_d_vld,
  input  logic [DATA_WIDTH-1:0]           i_rd_data,
  input  logic                            i_rd_data_valid,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] i_alu_out,
  input  logic                            i_out_valid,
  input  logic                            i_fifo_full,
  output logic                            o_alu_en,
  output logic [3:0]                      o_alu_fun,
  output logic                            o_clkg_en,
  output logic                            o_clkdiv_en,
  output logic [ADDR_WIDTH-1:0]           o_address,
  output logic                            o_wr_en,
  output logic                            o_rd_en,
  output logic [DATA_WIDTH-1:0]           o_wr_data,
  output logic [DATA_WIDTH-1:0]           o_wr_data_fifo,
  output logic                            o_wr_inc,
  output logic                            o_frame_err
);

  localparam int RES_W  = RES_BYTES * DATA_WIDTH;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BCNT_W = (RES_BYTES > 1) ? $clog2(RES_BYTES + 1) : 1;

  // The counter is compared one short of TIMEOUT: the abort takes effect on
  // the edge at which the count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_PUSH
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [RES_W-1:0]        r_res;
  logic [BCNT_W-1:0]       r_tx_left;

  logic                    r_alu_en;
  logic [3:0]              r_alu_fun;
  logic                    r_clkg_en;
  logic                    r_clkdiv_en;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic                    r_wr_en;
  logic                    r_rd_en;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH-1:0]   r_wr_data_fifo;
  logic                    r_wr_inc;
  logic                    r_frame_err;

  logic                    w_activity;
  logic                    w_timeout;

  // Any handshake from either side proves the frame is still alive.
  assign w_activity = i_rx_d_vld | i_rd_data_valid | i_out_valid | r_wr_inc;
  assign w_timeout  = (TIMEOUT != 0) && (r_state != IDLE) && (r_cnt == TO_LAST);

  // NOTE: every register here is sequential state, so it is assigned with
  // non-blocking (<=) assignments; blocking ones would make the result depend
  // on statement order and on how the simulator schedules other blocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_wr_addr      <= '0;
      r_res          <= '0;
      r_tx_left      <= '0;
      r_alu_en       <= 1'b0;
      r_alu_fun      <= '0;
      r_clkg_en      <= 1'b0;
      r_clkdiv_en    <= 1'b0;
      r_address      <= '0;
      r_wr_en        <= 1'b0;
      r_rd_en        <= 1'b0;
      r_wr_data      <= '0;
      r_wr_data_fifo <= '0;
      r_wr_inc       <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_clkdiv_en <= 1'b1;

      // Single-cycle strobes default low; states below raise them.
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_inc    <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == IDLE || w_activity || TIMEOUT == 0) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + CNT_W'(1);

      if (w_timeout) begin
        // Abort wins over anything arriving this cycle; such a byte is lost.
        r_frame_err <= 1'b1;
        r_alu_en    <= 1'b0;
        r_clkg_en   <= 1'b0;
        r_state     <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (i_rx_d_vld) begin
              if      (i_rx_p_data == OP_WR)    r_state <= WR_ADDR;
              else if (i_rx_p_data == OP_RD)    r_state <= RD_ADDR;
              else if (i_rx_p_data == OP_ALU)   r_state <= ALU_A;
              else if (i_rx_p_data == OP_ALUNP) r_state <= ALU_FUN;
              else                              r_frame_err <= 1'b1;
            end
          end

          WR_ADDR: begin
            if (i_rx_d_vld) begin
              r_wr_addr <= i_rx_p_data[ADDR_WIDTH-1:0];
              r_state   <= WR_DATA;
            end
          end

          WR_DATA: begin
            if (i_rx_d_vld) begin
              r_address <= r_wr_addr;
              r_wr_data <= i_rx_p_data;
              r_wr_en   <= 1'b1;
              r_state   <= IDLE;
            end
          end

          RD_ADDR: begin
            if (i_rx_d_vld) begin
              r_address <= i_rx_p_data[ADDR_WIDTH-1:0];
              r_rd_en   <= 1'b1;
              r_state   <= RD_WAIT;
            end
          end

          RD_WAIT: begin
            if (i_rx_d_vld) r_frame_err <= 1'b1;
            if (i_rd_data_valid) begin
              r_res     <= RES_W'(i_rd_data);
              r_tx_left <= BCNT_W'(1);
              r_state   <= TX_PUSH;
            end
          end

          ALU_A, ALU_B: begin
            // Operand A lives in register 0, operand B in register 1.
            if (i_rx_d_vld) begin
              r_address <= (r_state == ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
              r_wr_data <= i_rx_p_data;
              r_wr_en   <= 1'b1;
              r_state   <= (r_state == ALU_A) ? ALU_B : ALU_FUN;
            end
          end

          ALU_FUN: begin
            if (i_rx_d_vld) begin
              r_alu_fun <= i_rx_p_data[3:0];
              r_alu_en  <= 1'b1;
              r_clkg_en <= 1'b1;
              r_state   <= ALU_WAIT;
            end
          end

          ALU_WAIT: begin
            if (i_rx_d_vld) r_frame_err <= 1'b1;
            if (i_out_valid) begin
              r_res     <= i_alu_out;
              r_tx_left <= BCNT_W'(RES_BYTES);
              r_alu_en  <= 1'b0;
              r_clkg_en <= 1'b0;
              r_state   <= TX_PUSH;
            end
          end

          TX_PUSH: begin
            if (i_rx_d_vld) r_frame_err <= 1'b1;
            // Under back-pressure nothing moves: the byte register and the
            // remaining count are untouched, so no byte is lost or repeated.
            if (!i_fifo_full) begin
              r_wr_inc       <= 1'b1;
              r_wr_data_fifo <= r_res[DATA_WIDTH-1:0];
              r_res          <= r_res >> DATA_WIDTH;
              r_tx_left      <= r_tx_left - BCNT_W'(1);
              if (r_tx_left == BCNT_W'(1)) r_state <= IDLE;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_alu_en       = r_alu_en;
  assign o_alu_fun      = r_alu_fun;
  assign o_clkg_en      = r_clkg_en;
  assign o_clkdiv_en    = r_clkdiv_en;
  assign o_address      = r_address;
  assign o_wr_en        = r_wr_en;
  assign o_rd_en        = r_rd_en;
  assign o_wr_data      = r_wr_data;
  assign o_wr_data_fifo = r_wr_data_fifo;
  assign o_wr_inc       = r_wr_inc;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_sys_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_param
//   Directed bench for sys_ctrl_param (TIMEOUT = 15). Stimulus pushes the
//   strobe events it expects (register write/read, FIFO byte, frame error)
//   into a queue; a negedge monitor pops and compares one entry for every
//   strobe the DUT raises. Level outputs (ALU enables, held FIFO data, reset
//   values) are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_sys_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] alu_out;
  logic        out_valid;
  logic        fifo_full;

  logic        o_alu_en, o_clkg_en, o_clkdiv_en, o_wr_en, o_rd_en, o_wr_inc, o_frame_err;
  logic [3:0]  o_alu_fun;
  logic [3:0]  o_address;
  logic [7:0]  o_wr_data, o_wr_data_fifo;

  sys_ctrl_param #(.TIMEOUT(15)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx_p_data     (rx_data),
    .i_rx_d_vld      (rx_vld),
    .i_rd_data       (rd_data),
    .i_rd_data_valid (rd_valid),
    .i_alu_out       (alu_out),
    .i_out_valid     (out_valid),
    .i_fifo_full     (fifo_full),
    .o_alu_en        (o_alu_en),
    .o_alu_fun       (o_alu_fun),
    .o_clkg_en       (o_clkg_en),
    .o_clkdiv_en     (o_clkdiv_en),
    .o_address       (o_address),
    .o_wr_en         (o_wr_en),
    .o_rd_en         (o_rd_en),
    .o_wr_data       (o_wr_data),
    .o_wr_data_fifo  (o_wr_data_fifo),
    .o_wr_inc        (o_wr_inc),
    .o_frame_err     (o_frame_err)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_WR = 2'd0, EV_RD = 2'd1, EV_TX = 2'd2, EV_ERR = 2'd3} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void expect_ev(ev_kind_t k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_kind_t k, input logic [7:0] a, input logic [7:0] d);
    ev_t act;
    ev_t exp;
    act.kind = k;
    act.addr = a;
    act.data = d;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got %h, expected none (t=%0t)", act, $time);
    end else begin
      exp = exp_q.pop_front();
      check("event", act, exp);
    end
  endtask

  // Monitor: every strobe the DUT raises must match the next queued event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_wr_en)     observe(EV_WR,  8'(o_address), o_wr_data);
      if (o_rd_en)     observe(EV_RD,  8'(o_address), 8'h00);
      if (o_wr_inc)    observe(EV_TX,  8'h00, o_wr_data_fifo);
      if (o_frame_err) observe(EV_ERR, 8'h00, 8'h00);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic wait_rd_en();
    int k;
    for (k = 0; k < 20 && !o_rd_en; k++) @(negedge clk);
    if (!o_rd_en) check("rd_en_timeout", 64'(o_rd_en), 64'd1);
  endtask

  task automatic wait_alu_en();
    int k;
    for (k = 0; k < 20 && !o_alu_en; k++) @(negedge clk);
    if (!o_alu_en) check("alu_en_timeout", 64'(o_alu_en), 64'd1);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_alu_en, o_clkg_en, o_clkdiv_en, o_wr_en, o_rd_en, o_wr_inc,
                o_frame_err, o_alu_fun, o_address, o_wr_data, o_wr_data_fifo});
  endfunction

  initial begin
    int cycles;
    rst_n = 1'b0; rx_data = '0; rx_vld = 1'b0; rd_data = '0; rd_valid = 1'b0;
    alu_out = '0; out_valid = 1'b0; fifo_full = 1'b0;

    // Reset values, then CLKDIV_EN rises on the first clock out of reset.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("clkdiv_en_after_reset", 64'(o_clkdiv_en), 64'd1);

    // T1: register write.
    expect_ev(EV_WR, 8'h05, 8'h3C);
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("t1_drain");

    // T2: register read, data returned two cycles after RdEN.
    expect_ev(EV_RD, 8'h05, 8'h00);
    expect_ev(EV_TX, 8'h00, 8'h3C);
    send(8'hBB); send(8'h05);
    wait_rd_en();
    repeat (2) @(negedge clk);
    rd_data = 8'h3C; rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    drain("t2_drain");

    // T3: ALU with operands, two result bytes LSB first.
    expect_ev(EV_WR, 8'h00, 8'h12);
    expect_ev(EV_WR, 8'h01, 8'h34);
    expect_ev(EV_TX, 8'h00, 8'h46);
    expect_ev(EV_TX, 8'h00, 8'h00);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    wait_alu_en();
    check("t3_alu_fun", 64'(o_alu_fun), 64'h0);
    check("t3_clkg_en", 64'(o_clkg_en), 64'd1);
    repeat (3) @(negedge clk);
    check("t3_alu_en_held", 64'(o_alu_en), 64'd1);
    alu_out = 16'h0046; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    check("t3_alu_en_dropped", 64'({o_alu_en, o_clkg_en}), 64'd0);
    drain("t3_drain");

    // T4: FIFO full for 5 cycles after the first byte of a push.
    expect_ev(EV_WR, 8'h00, 8'h01);
    expect_ev(EV_WR, 8'h01, 8'h02);
    expect_ev(EV_TX, 8'h00, 8'h5A);
    expect_ev(EV_TX, 8'h00, 8'hA5);
    send(8'hCC); send(8'h01); send(8'h02); send(8'h05);
    wait_alu_en();
    check("t4_alu_fun", 64'(o_alu_fun), 64'h5);
    alu_out = 16'hA55A; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_wr_inc_stalled", 64'(o_wr_inc), 64'd0);
      check("t4_data_held", 64'(o_wr_data_fifo), 64'h5A);
    end
    fifo_full = 1'b0;
    drain("t4_drain");

    // ALU without operands; a stray byte during ALU_WAIT is dropped with an error.
    expect_ev(EV_ERR, 8'h00, 8'h00);
    expect_ev(EV_TX, 8'h00, 8'h34);
    expect_ev(EV_TX, 8'h00, 8'h12);
    send(8'hDD); send(8'h07);
    wait_alu_en();
    check("alunp_alu_fun", 64'(o_alu_fun), 64'h7);
    send(8'h99);
    alu_out = 16'h1234; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    drain("alunp_drain");

    // T5: frame stalls after the address byte; abort after 15 idle cycles.
    expect_ev(EV_ERR, 8'h00, 8'h00);
    send(8'hAA); send(8'h05);
    cycles = 0;
    while (!o_frame_err && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("t5_timeout_cycles", 64'(cycles), 64'd15);
    drain("t5_drain");
    expect_ev(EV_WR, 8'h06, 8'h77);
    send(8'hAA); send(8'h06); send(8'h77);
    drain("t5_next_frame");

    // T6: unknown opcode, then reset in the middle of ALU_WAIT.
    expect_ev(EV_ERR, 8'h00, 8'h00);
    send(8'h77);
    drain("t6_bad_opcode");
    expect_ev(EV_WR, 8'h00, 8'h0A);
    expect_ev(EV_WR, 8'h01, 8'h0B);
    send(8'hCC); send(8'h0A); send(8'h0B); send(8'h02);
    wait_alu_en();
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_alu_en_after_reset", 64'({o_alu_en, o_clkg_en, o_clkdiv_en}), 64'b001);
    drain("t6_pre_reset");
    expect_ev(EV_WR, 8'h03, 8'hC3);
    send(8'hAA); send(8'h03); send(8'hC3);
    drain("t6_idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
